// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped write-back/write-allocate data cache and controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int INDEX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 16 - INDEX_W - 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WB0   = 4'd1,
    S_WB1   = 4'd2,
    S_WB2   = 4'd3,
    S_WB3   = 4'd4,
    S_FILL0 = 4'd5,
    S_FILL1 = 4'd6,
    S_FILL2 = 4'd7,
    S_FILL3 = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES][4];

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [1:0]         w_off;
  logic               w_req;
  logic               w_illegal;
  logic               w_line_hit;
  logic [1:0]         w_k;
  logic               w_store;
  logic               w_fill_we;
  logic               w_fill_last;

  assign w_tag      = addr[15:INDEX_W+3];
  assign w_idx      = addr[INDEX_W+2:3];
  assign w_off      = addr[2:1];
  assign w_req      = rd | wr;
  assign w_illegal  = (w_req & addr[0]) | (rd & wr);
  assign w_line_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

  // Word number of the current memory transfer, taken from the state encoding.
  always_comb begin
    w_k = 2'd0;
    case (state_q)
      S_WB1, S_FILL1: w_k = 2'd1;
      S_WB2, S_FILL2: w_k = 2'd2;
      S_WB3, S_FILL3: w_k = 2'd3;
      default:        w_k = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    data_out    = 16'h0000;
    done        = 1'b0;
    stall       = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    w_store     = 1'b0;
    w_fill_we   = 1'b0;
    w_fill_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_illegal) begin
          err  = 1'b1;
          done = 1'b1;
        end else if (w_req) begin
          if (w_line_hit) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            data_out  = rd ? data_q[w_idx][w_off] : 16'h0000;
            w_store   = wr;
          end else begin
            stall   = 1'b1;
            state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB0 : S_FILL0;
          end
        end
      end
      S_WB0, S_WB1, S_WB2, S_WB3: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[w_idx], w_idx, w_k, 1'b0};
        mem_wdata = data_q[w_idx][w_k];
        // WB3 + 1 is FILL0 in the encoding, so the sequence is a plain increment.
        if (mem_ack) state_d = state_t'(state_q + 4'd1);
      end
      S_FILL0, S_FILL1, S_FILL2, S_FILL3: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, w_k, 1'b0};
        if (mem_ack) begin
          w_fill_we   = 1'b1;
          w_fill_last = (state_q == S_FILL3);
          state_d     = state_t'(state_q + 4'd1);
        end
      end
      S_DONE: begin
        done     = 1'b1;
        data_out = rd ? data_q[w_idx][w_off] : 16'h0000;
        w_store  = wr;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_store) dirty_q[w_idx] <= 1'b1;
      if (w_fill_last) begin
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill_we)   data_q[w_idx][w_k]   <= mem_rdata;
      if (w_fill_last) tag_q[w_idx]         <= w_tag;
      if (w_store)     data_q[w_idx][w_off] <= data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed self-checking bench for dcache_ctrl with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic        done, stall, cache_hit, err;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem_model [32768];
  int          ack_delay = 0;
  int          wcnt      = 0;
  logic [15:0] fill_q[$];
  logic [15:0] wb_addr_q[$];
  logic [15:0] wb_data_q[$];
  int          req_cycles = 0;
  int          addr_viol  = 0;
  logic        pend       = 1'b0;
  logic [15:0] paddr      = 16'h0000;

  int          lat, scnt;
  logic [15:0] dout;
  logic        hit, e;

  dcache_ctrl #(.INDEX_W(8)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .stall(stall), .cache_hit(cache_hit),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: acks each word after ack_delay waiting cycles.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model[mem_addr[15:1]];
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (mem_req) req_cycles = req_cycles + 1;
    if (pend && mem_req && (mem_addr !== paddr)) addr_viol = addr_viol + 1;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wb_addr_q.push_back(mem_addr);
        wb_data_q.push_back(mem_wdata);
        mem_model[mem_addr[15:1]] = mem_wdata;
      end else begin
        fill_q.push_back(mem_addr);
      end
    end
    pend  = mem_req && !mem_ack;
    paddr = mem_addr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int l, output logic [15:0] o,
                         output logic h, output logic er, output int sc);
    fill_q.delete();
    wb_addr_q.delete();
    wb_data_q.delete();
    req_cycles = 0;
    addr_viol  = 0;
    rd = r; wr = w; addr = a; data_in = d;
    l = -1; o = 16'h0000; h = 1'b0; er = 1'b0; sc = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); #1;
      if (stall) sc = sc + 1;
      if (done) begin
        l  = c;
        o  = data_out;
        h  = cache_hit;
        er = err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic check_fills(input string tag, input logic [15:0] base);
    check_eq({tag, "_nfill"}, fill_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check_eq({tag, "_fill_addr"}, (k < fill_q.size()) ? fill_q[k] : 16'hxxxx,
               base + 16'(2 * k));
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem_model[i] = 16'(i << 1) ^ 16'hC3A5;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_done", done, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_hit", cache_hit, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold load
    run_req(1, 0, 16'h0010, 0, lat, dout, hit, e, scnt);
    check_eq("cold_lat", lat, 5);
    check_eq("cold_hit", hit, 0);
    check_eq("cold_data", dout, 16'hC3B5);
    check_eq("cold_stall_cycles", scnt, 5);
    check_eq("cold_nwb", wb_addr_q.size(), 0);
    check_fills("cold", 16'h0010);

    // Hit after fill
    run_req(1, 0, 16'h0012, 0, lat, dout, hit, e, scnt);
    check_eq("hit_lat", lat, 0);
    check_eq("hit_flag", hit, 1);
    check_eq("hit_data", dout, 16'hC3B7);
    check_eq("hit_no_mem_req", req_cycles, 0);

    // Store hit then dirty eviction
    run_req(0, 1, 16'h0010, 16'hBEEF, lat, dout, hit, e, scnt);
    check_eq("st_lat", lat, 0);
    check_eq("st_hit", hit, 1);
    run_req(1, 0, 16'h0810, 0, lat, dout, hit, e, scnt);
    check_eq("evict_lat", lat, 9);
    check_eq("evict_hit", hit, 0);
    check_eq("evict_data", dout, 16'hCBB5);
    check_eq("evict_nwb", wb_addr_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check_eq("evict_wb_addr", (k < wb_addr_q.size()) ? wb_addr_q[k] : 16'hxxxx,
               16'h0010 + 16'(2 * k));
    check_eq("evict_wb_w0", (wb_data_q.size() > 0) ? wb_data_q[0] : 16'hxxxx, 16'hBEEF);
    check_eq("evict_wb_w1", (wb_data_q.size() > 1) ? wb_data_q[1] : 16'hxxxx, 16'hC3B7);
    check_eq("evict_wb_w3", (wb_data_q.size() > 3) ? wb_data_q[3] : 16'hxxxx, 16'hC3B3);
    check_fills("evict", 16'h0810);

    // Re-fetch of the written-back line (victim now clean)
    run_req(1, 0, 16'h0010, 0, lat, dout, hit, e, scnt);
    check_eq("refetch_lat", lat, 5);
    check_eq("refetch_data", dout, 16'hBEEF);
    check_eq("refetch_nwb", wb_addr_q.size(), 0);

    // Illegal requests
    run_req(1, 0, 16'h0011, 0, lat, dout, hit, e, scnt);
    check_eq("err_odd_lat", lat, 0);
    check_eq("err_odd_flag", e, 1);
    check_eq("err_odd_hit", hit, 0);
    check_eq("err_odd_no_req", req_cycles, 0);
    run_req(1, 1, 16'h0010, 16'h1111, lat, dout, hit, e, scnt);
    check_eq("err_rdwr_flag", e, 1);
    run_req(0, 1, 16'h0013, 16'h2222, lat, dout, hit, e, scnt);
    check_eq("err_odd_wr_flag", e, 1);
    run_req(1, 0, 16'h0010, 0, lat, dout, hit, e, scnt);
    check_eq("err_unchanged_hit", hit, 1);
    check_eq("err_unchanged_data", dout, 16'hBEEF);

    // Slow memory
    ack_delay = 3;
    run_req(1, 0, 16'h1020, 0, lat, dout, hit, e, scnt);
    check_eq("slow_lat", lat, 17);
    check_eq("slow_data", dout, 16'hD385);
    check_eq("slow_addr_stable", addr_viol, 0);
    check_fills("slow", 16'h1020);
    ack_delay = 0;

    // Reset during FILL2
    rd = 1'b1; addr = 16'h2030;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("midrst_fill2_addr", mem_addr, 16'h2034);
    check_eq("midrst_fill2_stall", stall, 1);
    rst = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("midrst_mem_req", mem_req, 0);
    check_eq("midrst_stall", stall, 0);
    check_eq("midrst_done", done, 0);
    @(posedge clk); #1;
    run_req(1, 0, 16'h2030, 0, lat, dout, hit, e, scnt);
    check_eq("midrst_refill_lat", lat, 5);
    check_eq("midrst_refill_hit", hit, 0);
    check_eq("midrst_refill_data", dout, 16'hE395);
    check_fills("midrst", 16'h2030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
